ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding and load-use hazard logic; sits directly upstream of the ALU.
- Captures decoded operands and controls, resolves RAW hazards from the MEM and WB stages, and drives the ALU's SrcA/SrcB/3-bit ALU control.
- Its stall output holds the fetch and decode stages.

Parameters:
- width, 32, datapath width.
- addr_w, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ValidD  in  1  decode slot holds a real instruction.
- Rs1D, Rs2D, RdD  in  addr_w each  source and destination register numbers.
- RD1D, RD2D  in  width each  register-file read data.
- ImmExtD  in  width  sign-extended immediate.
- ALUControlD  in  3  ALU operation code.
- ALUSrcD  in  1  1 = SrcB takes the immediate.
- RegWriteD, MemReadD, MemWriteD  in  1 each  control bits for later stages.
- FlushE  in  1  kill the instruction entering EX (branch taken).
- StallE  in  1  downstream hold; EX register keeps its contents.
- RdM  in  addr_w  MEM-stage destination register.
- RegWriteM  in  1  MEM-stage write enable.
- ALUResultM  in  width  MEM-stage ALU result.
- RdW  in  addr_w  WB-stage destination register.
- RegWriteW  in  1  WB-stage write enable.
- ResultW  in  width  WB-stage result.
- SrcA, SrcB  out  width each  ALU operands.
- ALUControlE  out  3  to the ALU.
- WriteDataE  out  width  forwarded rs2 value, used as store data.
- RdE  out  addr_w  destination register in EX.
- RegWriteE, MemReadE, MemWriteE, ValidE  out  1 each  EX-stage controls.
- StallD  out  1  hold PC and the IF/ID register.

Behaviour:
- Register update priority on each rising edge of clk (highest first):
  - reset: clear every EX field to 0.
  - FlushE: load a bubble.
  - StallE: hold all fields.
  - Load-use hazard: load a bubble.
  - Otherwise: capture all D-side inputs.
- Bubble definition: ValidE, RegWriteE, MemReadE, MemWriteE = 0; data fields, RdE and ALUControlE = 0.
- Reset values:
  - Every output is 0, including SrcA, SrcB, WriteDataE and StallD, until the first capture.
  - Reset asserted mid-stall or mid-hazard overrides everything; StallD is 0 in the cycle after reset.
- Load-use hazard (combinational):
  - Condition: MemReadE & ValidE & ValidD & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
  - Conservative: compares both source fields regardless of whether the instruction uses them.
  - StallD = hazard | StallE.
  - The hazard inserts exactly one bubble. The load then sits in MEM; on the next edge it reaches WB and the held instruction enters EX, where it forwards from WB.
- Forwarding (combinational, from the registered Rs1E/Rs2E):
  - MEM source used when RegWriteM & RdM!=0 & RdM==RsxE.
  - Else WB source when RegWriteW & RdW!=0 & RdW==RsxE.
  - Else the registered RD1E/RD2E.
  - MEM wins when both match.
  - Register x0 is never forwarded and always reads as the registered value.
- Operand outputs:
  - SrcA = forwarded rs1 value.
  - WriteDataE = forwarded rs2 value.
  - SrcB = ImmExtE if ALUSrcE, else the forwarded rs2 value.
- Forwarding is also evaluated on bubbles; this is harmless because all bubble controls are 0.
- Latency: one cycle from D inputs to E outputs. Forward paths have zero cycles of latency (purely combinational).
- FlushE together with a hazard: flush wins, and StallD still reflects the hazard.
- StallE together with FlushE: flush wins.

Test Plan:
- Reset, then capture `add`: RD1D=5, RD2D=7, Rs1D=1, Rs2D=2, ALUControlD=000, ALUSrcD=0 -> next cycle SrcA=5, SrcB=7, ALUControlE=000, ValidE=1.
- MEM over WB priority: Rs1E=3, RegWriteM=1, RdM=3, ALUResultM=0x10, RegWriteW=1, RdW=3, ResultW=0x20 -> SrcA=0x10. With RegWriteM=0 -> SrcA=0x20.
- x0: Rs2E=0, RdM=0, RegWriteM=1, ALUResultM=0xFF, RD2E=0 -> SrcB=0 and WriteDataE=0.
- Load-use: load with RdE=4 in EX, then decode Rs1D=4 -> StallD=1 for one cycle, a bubble enters EX (ValidE=0, RegWriteE=0). Next cycle ResultW=0x55 with RdW=4 -> SrcA=0x55.
- StallE held for 3 cycles with changing D inputs -> all E outputs constant and StallD=1. FlushE asserted during the stall -> bubble on the next edge.
- Reset asserted during a load-use stall -> all outputs 0 next cycle and StallD=0.

Source files
------------

// File: rtl/ex_operand_stage_if.sv
// ID/EX operand-stage bus: decode-side inputs, MEM/WB forwarding sources,
// pipeline controls and the EX-stage outputs that feed the ALU.
interface ex_operand_stage_if #(
    parameter int unsigned width  = 32,
    parameter int unsigned addr_w = 5
);
    // Decode slot
    logic              ValidD;
    logic [addr_w-1:0] Rs1D;
    logic [addr_w-1:0] Rs2D;
    logic [addr_w-1:0] RdD;
    logic [width-1:0]  RD1D;
    logic [width-1:0]  RD2D;
    logic [width-1:0]  ImmExtD;
    logic [2:0]        ALUControlD;
    logic              ALUSrcD;
    logic              RegWriteD;
    logic              MemReadD;
    logic              MemWriteD;

    // Pipeline control
    logic              FlushE;
    logic              StallE;

    // Forwarding sources
    logic [addr_w-1:0] RdM;
    logic              RegWriteM;
    logic [width-1:0]  ALUResultM;
    logic [addr_w-1:0] RdW;
    logic              RegWriteW;
    logic [width-1:0]  ResultW;

    // EX-stage outputs
    logic [width-1:0]  SrcA;
    logic [width-1:0]  SrcB;
    logic [2:0]        ALUControlE;
    logic [width-1:0]  WriteDataE;
    logic [addr_w-1:0] RdE;
    logic              RegWriteE;
    logic              MemReadE;
    logic              MemWriteE;
    logic              ValidE;
    logic              StallD;

    // Upstream pipeline / environment side
    modport master (
        output ValidD, Rs1D, Rs2D, RdD, RD1D, RD2D, ImmExtD, ALUControlD,
               ALUSrcD, RegWriteD, MemReadD, MemWriteD,
               FlushE, StallE,
               RdM, RegWriteM, ALUResultM, RdW, RegWriteW, ResultW,
        input  SrcA, SrcB, ALUControlE, WriteDataE, RdE,
               RegWriteE, MemReadE, MemWriteE, ValidE, StallD
    );

    // Operand stage side
    modport slave (
        input  ValidD, Rs1D, Rs2D, RdD, RD1D, RD2D, ImmExtD, ALUControlD,
               ALUSrcD, RegWriteD, MemReadD, MemWriteD,
               FlushE, StallE,
               RdM, RegWriteM, ALUResultM, RdW, RegWriteW, ResultW,
        output SrcA, SrcB, ALUControlE, WriteDataE, RdE,
               RegWriteE, MemReadE, MemWriteE, ValidE, StallD
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use
// hazard detection; drives the ALU operands and the decode-stage stall.
module ex_operand_stage #(
    parameter int unsigned width  = 32,
    parameter int unsigned addr_w = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    ex_operand_stage_if.slave    ex_if
);

    // Everything the EX stage needs to remember about one instruction
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              alu_src;
        logic [2:0]        alu_ctrl;
        logic [addr_w-1:0] rs1;
        logic [addr_w-1:0] rs2;
        logic [addr_w-1:0] rd;
        logic [width-1:0]  rd1;
        logic [width-1:0]  rd2;
        logic [width-1:0]  imm;
    } ex_reg_t;

    ex_reg_t           ex_q;
    ex_reg_t           ex_d;
    ex_reg_t           d_slot;
    logic              load_use;
    logic [width-1:0]  fwd_a;
    logic [width-1:0]  fwd_b;

    // Pack the decode-side inputs into the EX register layout
    always_comb begin
        d_slot           = '0;
        d_slot.valid     = ex_if.ValidD;
        d_slot.reg_write = ex_if.RegWriteD;
        d_slot.mem_read  = ex_if.MemReadD;
        d_slot.mem_write = ex_if.MemWriteD;
        d_slot.alu_src   = ex_if.ALUSrcD;
        d_slot.alu_ctrl  = ex_if.ALUControlD;
        d_slot.rs1       = ex_if.Rs1D;
        d_slot.rs2       = ex_if.Rs2D;
        d_slot.rd        = ex_if.RdD;
        d_slot.rd1       = ex_if.RD1D;
        d_slot.rd2       = ex_if.RD2D;
        d_slot.imm       = ex_if.ImmExtD;
    end

    // Load in EX whose destination is read by decode; both source fields
    // are compared whether or not the instruction actually uses them
    always_comb begin
        load_use = ex_q.mem_read & ex_q.valid & ex_if.ValidD
                 & (ex_q.rd != '0)
                 & ((ex_if.Rs1D == ex_q.rd) | (ex_if.Rs2D == ex_q.rd));
    end

    // Next EX contents: flush beats stall, stall beats hazard bubble
    always_comb begin
        ex_d = ex_q;
        if (ex_if.FlushE) begin
            ex_d = '0;
        end else if (ex_if.StallE) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d = '0;
        end else begin
            ex_d = d_slot;
        end
    end

    // EX pipeline register; a bubble is the all-zero word
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // rs1 forwarding: MEM has the younger value, x0 is never forwarded
    always_comb begin
        fwd_a = ex_q.rd1;
        if (ex_if.RegWriteM && (ex_if.RdM != '0) && (ex_if.RdM == ex_q.rs1)) begin
            fwd_a = ex_if.ALUResultM;
        end else if (ex_if.RegWriteW && (ex_if.RdW != '0) && (ex_if.RdW == ex_q.rs1)) begin
            fwd_a = ex_if.ResultW;
        end
    end

    // rs2 forwarding, same priority as rs1
    always_comb begin
        fwd_b = ex_q.rd2;
        if (ex_if.RegWriteM && (ex_if.RdM != '0) && (ex_if.RdM == ex_q.rs2)) begin
            fwd_b = ex_if.ALUResultM;
        end else if (ex_if.RegWriteW && (ex_if.RdW != '0) && (ex_if.RdW == ex_q.rs2)) begin
            fwd_b = ex_if.ResultW;
        end
    end

    // ALU operands, store data and EX-stage controls
    assign ex_if.SrcA        = fwd_a;
    assign ex_if.SrcB        = ex_q.alu_src ? ex_q.imm : fwd_b;
    assign ex_if.WriteDataE  = fwd_b;
    assign ex_if.ALUControlE = ex_q.alu_ctrl;
    assign ex_if.RdE         = ex_q.rd;
    assign ex_if.RegWriteE   = ex_q.reg_write;
    assign ex_if.MemReadE    = ex_q.mem_read;
    assign ex_if.MemWriteE   = ex_q.mem_write;
    assign ex_if.ValidE      = ex_q.valid;
    assign ex_if.StallD      = load_use | ex_if.StallE;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: expected EX outputs are queued
// as each decode slot is driven and compared one edge later.
module tb_ex_operand_stage;

    logic clk;
    logic reset;

    ex_operand_stage_if #(.width(32), .addr_w(5)) bus ();

    ex_operand_stage #(.width(32), .addr_w(5)) dut (
        .clk   (clk),
        .reset (reset),
        .ex_if (bus)
    );

    typedef struct packed {
        logic [31:0] srca;
        logic [31:0] srcb;
        logic [31:0] wd;
        logic [2:0]  aluc;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        v;
    } eout_t;

    eout_t sb[$];
    eout_t exp_e;
    eout_t act_e;
    int    checks;
    int    errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                           input logic [31:0] imm, input logic [2:0] aluc, input logic alusrc,
                           input logic rw, input logic mr, input logic mw);
        bus.ValidD      = v;
        bus.Rs1D        = rs1;
        bus.Rs2D        = rs2;
        bus.RdD         = rd;
        bus.RD1D        = rd1;
        bus.RD2D        = rd2;
        bus.ImmExtD     = imm;
        bus.ALUControlD = aluc;
        bus.ALUSrcD     = alusrc;
        bus.RegWriteD   = rw;
        bus.MemReadD    = mr;
        bus.MemWriteD   = mw;
    endtask

    task automatic set_fwd(input logic rwm, input logic [4:0] rdm, input logic [31:0] alum,
                           input logic rww, input logic [4:0] rdw, input logic [31:0] resw);
        bus.RegWriteM  = rwm;
        bus.RdM        = rdm;
        bus.ALUResultM = alum;
        bus.RegWriteW  = rww;
        bus.RdW        = rdw;
        bus.ResultW    = resw;
    endtask

    task automatic sample();
        act_e = {bus.SrcA, bus.SrcB, bus.WriteDataE, bus.ALUControlE, bus.RdE,
                 bus.RegWriteE, bus.MemReadE, bus.MemWriteE, bus.ValidE};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one edge, pop the oldest expectation and sample the DUT
    task automatic tick_pop();
        @(posedge clk);
        #1;
        exp_e = (sb.size() > 0) ? sb.pop_front() : '1;
        sample();
    endtask

    function automatic eout_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                                 input logic [2:0] c, input logic [4:0] rd, input logic rw,
                                 input logic mr, input logic mw, input logic v);
        return {a, b, w, c, rd, rw, mr, mw, v};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        drive_d(1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b111, 1, 1, 1, 1);
        sb.push_back('0);
        tick_pop();
        checks++;
        if (act_e !== exp_e) begin
            errors++; $display("FAIL reset_outputs: got %h want %h", act_e, exp_e);
        end
        checks++;
        if (bus.StallD !== 1'b0) begin
            errors++; $display("FAIL reset_stalld: got %b want 0", bus.StallD);
        end
        reset = 1'b0;
        drive_d(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_capture();
        set_fwd(0, 0, 0, 0, 0, 0);
        drive_d(1, 5'd1, 5'd2, 5'd9, 32'd5, 32'd7, 32'h0, 3'b000, 0, 1, 0, 0);
        sb.push_back(mk(32'd5, 32'd7, 32'd7, 3'b000, 5'd9, 1, 0, 0, 1));
        tick_pop();
        checks++;
        if (act_e !== exp_e) begin
            errors++; $display("FAIL capture_add: got %h want %h", act_e, exp_e);
        end
        drive_d(1, 5'd6, 5'd7, 5'd8, 32'h11, 32'h22, 32'h100, 3'b010, 1, 0, 0, 1);
        sb.push_back(mk(32'h11, 32'h100, 32'h22, 3'b010, 5'd8, 0, 0, 1, 1));
        tick_pop();
        checks++;
        if (act_e !== exp_e) begin
            errors++; $display("FAIL capture_imm: got %h want %h", act_e, exp_e);
        end
    endtask

    task automatic test_fwd_priority();
        set_fwd(1, 5'd3, 32'h10, 1, 5'd3, 32'h20);
        drive_d(1, 5'd3, 5'd5, 5'd6, 32'hAAA, 32'hBBB, 32'h0, 3'b001, 0, 1, 0, 0);
        sb.push_back(mk(32'h10, 32'hBBB, 32'hBBB, 3'b001, 5'd6, 1, 0, 0, 1));
        tick_pop();
        checks++;
        if (act_e !== exp_e) begin
            errors++; $display("FAIL fwd_mem_over_wb: got %h want %h", act_e, exp_e);
        end
        bus.RegWriteM = 1'b0;
        #1;
        checks++;
        if (bus.SrcA !== 32'h20) begin
            errors++; $display("FAIL fwd_wb_only: got %h want %h", bus.SrcA, 32'h20);
        end
        set_fwd(1, 5'd3, 32'h10, 1, 5'd5, 32'h20);
        #1;
        sample();
        exp_e = mk(32'h10, 32'h20, 32'h20, 3'b001, 5'd6, 1, 0, 0, 1);
        checks++;
        if (act_e !== exp_e) begin
            errors++; $display("FAIL fwd_split_rs1_mem_rs2_wb: got %h want %h", act_e, exp_e);
        end
    endtask

    task automatic test_x0();
        set_fwd(1, 5'd0, 32'hFF, 1, 5'd0, 32'hEE);
        drive_d(1, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, 3'b000, 0, 1, 0, 0);
        sb.push_back(mk(32'h0, 32'h0, 32'h0, 3'b000, 5'd1, 1, 0, 0, 1));
        tick_pop();
        checks++;
        if (act_e !== exp_e) begin
            errors++; $display("FAIL x0_not_forwarded: got %h want %h", act_e, exp_e);
        end
    endtask

    task automatic test_load_use();
        set_fwd(0, 0, 0, 0, 0, 0);
        drive_d(1, 5'd1, 5'd0, 5'd4, 32'h1000, 32'h0, 32'h8, 3'b000, 1, 1, 1, 0);
        sb.push_back(mk(32'h1000, 32'h8, 32'h0, 3'b000, 5'd4, 1, 1, 0, 1));
        tick_pop();
        checks++;
        if (act_e !== exp_e) begin
            errors++; $display("FAIL load_capture: got %h want %h", act_e, exp_e);
        end
        drive_d(1, 5'd4, 5'd2, 5'd5, 32'hDEAD, 32'h3, 32'h0, 3'b000, 0, 1, 0, 0);
        #1;
        checks++;
        if (bus.StallD !== 1'b1) begin
            errors++; $display("FAIL load_use_stalld: got %b want 1", bus.StallD);
        end
        sb.push_back('0);
        tick_pop();
        checks++;
        if (act_e !== exp_e) begin
            errors++; $display("FAIL load_use_bubble: got %h want %h", act_e, exp_e);
        end
        checks++;
        if (bus.StallD !== 1'b0) begin
            errors++; $display("FAIL load_use_release: got %b want 0", bus.StallD);
        end
        set_fwd(0, 0, 0, 1, 5'd4, 32'h55);
        sb.push_back(mk(32'h55, 32'h3, 32'h3, 3'b000, 5'd5, 1, 0, 0, 1));
        tick_pop();
        checks++;
        if (act_e !== exp_e) begin
            errors++; $display("FAIL load_use_wb_forward: got %h want %h", act_e, exp_e);
        end
    endtask

    task automatic test_stall_flush();
        eout_t held;
        set_fwd(0, 0, 0, 0, 0, 0);
        drive_d(1, 5'd10, 5'd11, 5'd12, 32'h111, 32'h222, 32'h0, 3'b101, 0, 1, 0, 0);
        held = mk(32'h111, 32'h222, 32'h222, 3'b101, 5'd12, 1, 0, 0, 1);
        sb.push_back(held);
        tick_pop();
        checks++;
        if (act_e !== exp_e) begin
            errors++; $display("FAIL stall_setup: got %h want %h", act_e, exp_e);
        end
        bus.StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_d(1, 5'(i + 1), 5'(i + 2), 5'(i + 20), $urandom, $urandom, $urandom,
                    3'(i), 1'(i), 1, 0, 1);
            #1;
            checks++;
            if (bus.StallD !== 1'b1) begin
                errors++; $display("FAIL stall_stalld[%0d]: got %b want 1", i, bus.StallD);
            end
            sb.push_back(held);
            tick_pop();
            checks++;
            if (act_e !== exp_e) begin
                errors++; $display("FAIL stall_hold[%0d]: got %h want %h", i, act_e, exp_e);
            end
        end
        bus.FlushE = 1'b1;
        sb.push_back('0);
        tick_pop();
        checks++;
        if (act_e !== exp_e) begin
            errors++; $display("FAIL flush_during_stall: got %h want %h", act_e, exp_e);
        end
        bus.StallE = 1'b0;
        bus.FlushE = 1'b0;
    endtask

    task automatic test_flush_hazard();
        set_fwd(0, 0, 0, 0, 0, 0);
        drive_d(1, 5'd1, 5'd2, 5'd4, 32'h40, 32'h0, 32'h4, 3'b000, 1, 1, 1, 0);
        sb.push_back(mk(32'h40, 32'h4, 32'h0, 3'b000, 5'd4, 1, 1, 0, 1));
        tick_pop();
        checks++;
        if (act_e !== exp_e) begin
            errors++; $display("FAIL flush_hazard_load: got %h want %h", act_e, exp_e);
        end
        drive_d(1, 5'd7, 5'd4, 5'd8, 32'h1, 32'h2, 32'h0, 3'b011, 0, 1, 0, 0);
        bus.FlushE = 1'b1;
        #1;
        checks++;
        if (bus.StallD !== 1'b1) begin
            errors++; $display("FAIL flush_hazard_stalld: got %b want 1", bus.StallD);
        end
        sb.push_back('0);
        tick_pop();
        checks++;
        if (act_e !== exp_e) begin
            errors++; $display("FAIL flush_hazard_bubble: got %h want %h", act_e, exp_e);
        end
        bus.FlushE = 1'b0;
    endtask

    task automatic test_reset_in_stall();
        set_fwd(0, 0, 0, 0, 0, 0);
        drive_d(1, 5'd1, 5'd2, 5'd9, 32'h90, 32'h0, 32'hC, 3'b000, 1, 1, 1, 0);
        sb.push_back(mk(32'h90, 32'hC, 32'h0, 3'b000, 5'd9, 1, 1, 0, 1));
        tick_pop();
        checks++;
        if (act_e !== exp_e) begin
            errors++; $display("FAIL reset_stall_load: got %h want %h", act_e, exp_e);
        end
        drive_d(1, 5'd9, 5'd3, 5'd10, 32'h5, 32'h6, 32'h0, 3'b000, 0, 1, 0, 0);
        #1;
        checks++;
        if (bus.StallD !== 1'b1) begin
            errors++; $display("FAIL reset_stall_pre: got %b want 1", bus.StallD);
        end
        reset = 1'b1;
        sb.push_back('0);
        tick_pop();
        checks++;
        if (act_e !== exp_e) begin
            errors++; $display("FAIL reset_stall_clear: got %h want %h", act_e, exp_e);
        end
        checks++;
        if (bus.StallD !== 1'b0) begin
            errors++; $display("FAIL reset_stall_stalld: got %b want 0", bus.StallD);
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        logic        s;
        logic [2:0]  c;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        set_fwd(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            a  = $urandom;
            b  = $urandom;
            im = $urandom;
            s  = 1'($urandom_range(0, 1));
            c  = 3'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 31));
            rw = 1'($urandom_range(0, 1));
            mw = 1'($urandom_range(0, 1));
            drive_d(1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), rd,
                    a, b, im, c, s, rw, 0, mw);
            sb.push_back(mk(a, s ? im : b, b, c, rd, rw, 0, mw, 1));
            tick_pop();
            checks++;
            if (act_e !== exp_e) begin
                errors++; $display("FAIL back_to_back[%0d]: got %h want %h", i, act_e, exp_e);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.FlushE = 1'b0;
        bus.StallE = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);
        drive_d(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        #1;
        tick();
        tick();
        test_reset();
        test_capture();
        test_fwd_priority();
        test_x0();
        test_load_use();
        test_stall_flush();
        test_flush_hazard();
        test_reset_in_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
